// File: rtl/insn_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Pure declarations and helpers; no state, no latency.
// No handshakes live here.
package insn_enc_pkg;

    typedef enum logic [3:0] {
        FMT_R      = 4'd0,
        FMT_I_ALU  = 4'd1,
        FMT_I_LD   = 4'd2,
        FMT_I_JALR = 4'd3,
        FMT_S      = 4'd4,
        FMT_B      = 4'd5,
        FMT_LUI    = 4'd6,
        FMT_AUIPC  = 4'd7,
        FMT_J      = 4'd8
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // True when value is representable as a width-bit two's-complement
    // number, i.e. bits [31:width-1] are all copies of the sign bit.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned width);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (width - 1);
        return ((value & mask) == 32'd0) || ((value & mask) == mask);
    endfunction

endpackage

// File: rtl/insn_enc_fifo.sv
// Two-entry 32-bit queue for encoded instruction words.
// Latency: a pushed word is visible at the head the following cycle.
// Pushes while full and pops while empty are ignored; the caller gates them.
module insn_enc_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_dat,
    input  logic        pop,
    output logic [31:0] head_dat,
    output logic        full,
    output logic        empty
);

    logic [31:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_wr;
    logic        do_rd;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_wr    = push && !full;
    assign do_rd    = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Storage, pointers and occupancy; reset drops everything queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/insn_enc.sv
// RV32I encoder: checks a decoded field bundle and assembles a legal 32-bit word.
// Latency: accept in cycle N -> word at the queue head (or err_o pulse) in N+1.
// req_rdy_o is !full from registered state only; a pop never frees a slot in the same cycle.
module insn_enc
    import insn_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_vld_i,
    output logic             req_rdy_o,
    input  logic [3:0]       fmt_i,
    input  logic [2:0]       funct3_i,
    input  logic             alt_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [31:0]      imm_i,
    output logic [31:0]      instr_o,
    output logic             instr_vld_o,
    input  logic             instr_rdy_i,
    output logic             err_o,
    output logic [CNT_W-1:0] insn_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    fmt_e        fmt;
    logic [6:0]  funct7;
    logic [31:0] enc_dat;
    logic        enc_err;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        shamt_ok;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [31:0] head_dat;

    assign fmt      = fmt_e'(fmt_i);
    assign funct7   = alt_i ? FUNCT7_ALT : FUNCT7_BASE;
    assign fits12   = fits_signed(imm_i, 12);
    assign fits13   = fits_signed(imm_i, 13);
    assign fits21   = fits_signed(imm_i, 21);
    assign shamt_ok = (imm_i[31:5] == 27'd0);

    assign req_rdy_o   = !full;
    assign accept      = req_vld_i && req_rdy_o;
    assign push        = accept && !enc_err;
    assign instr_vld_o = !empty;
    assign pop         = instr_vld_o && instr_rdy_i;
    assign instr_o     = empty ? 32'd0 : head_dat;

    // Assemble the word for the selected format and flag illegal field combinations.
    always_comb begin
        enc_dat = 32'd0;
        enc_err = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_dat = {funct7, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
                enc_err = alt_i && !((funct3_i == 3'b000) || (funct3_i == 3'b101));
            end
            FMT_I_ALU: begin
                case (funct3_i)
                    3'b001: begin
                        enc_dat = {FUNCT7_BASE, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
                        enc_err = alt_i || !shamt_ok;
                    end
                    3'b101: begin
                        enc_dat = {funct7, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
                        enc_err = !shamt_ok;
                    end
                    default: begin
                        enc_dat = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
                        enc_err = alt_i || !fits12;
                    end
                endcase
            end
            FMT_I_LD: begin
                enc_dat = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
                enc_err = !fits12 || (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
            end
            FMT_I_JALR: begin
                enc_dat = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_JALR};
                enc_err = !fits12 || (funct3_i != 3'b000);
            end
            FMT_S: begin
                enc_dat = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
                enc_err = !fits12 || (funct3_i[2] || (funct3_i[1:0] == 2'b11));
            end
            FMT_B: begin
                enc_dat = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OPC_BRANCH};
                enc_err = !fits13 || imm_i[0] || (funct3_i[2:1] == 2'b01);
            end
            FMT_LUI: begin
                enc_dat = {imm_i[31:12], rd_i, OPC_LUI};
                enc_err = (imm_i[11:0] != 12'd0);
            end
            FMT_AUIPC: begin
                enc_dat = {imm_i[31:12], rd_i, OPC_AUIPC};
                enc_err = (imm_i[11:0] != 12'd0);
            end
            FMT_J: begin
                enc_dat = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
                enc_err = !fits21 || imm_i[0];
            end
            default: begin
                enc_dat = 32'd0;
                enc_err = 1'b1;
            end
        endcase
    end

    insn_enc_fifo u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push),
        .push_dat (enc_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty)
    );

    // Error pulse and wrapping activity counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o      <= 1'b0;
            insn_cnt_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            err_o <= accept && enc_err;
            if (accept && enc_err) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
            if (pop) begin
                insn_cnt_o <= insn_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_insn_enc.sv
// Directed and random-legal stimulus for insn_enc with an expected-word queue.
// Words are compared at the consumer handshake; every word also goes through a validity decode.
// Exercises backpressure, reset with words queued, back-to-back errors and counter wrap.
module tb_insn_enc;
    import insn_enc_pkg::*;

    localparam int TB_CNT_W = 4;

    typedef struct {
        logic [31:0] word;
        logic [31:0] mask;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic                req_vld_i = 1'b0;
    logic                req_rdy_o;
    logic [3:0]          fmt_i = '0;
    logic [2:0]          funct3_i = '0;
    logic                alt_i = 1'b0;
    logic [4:0]          rd_i = '0;
    logic [4:0]          rs1_i = '0;
    logic [4:0]          rs2_i = '0;
    logic [31:0]         imm_i = '0;
    logic [31:0]         instr_o;
    logic                instr_vld_o;
    logic                instr_rdy_i = 1'b0;
    logic                err_o;
    logic [TB_CNT_W-1:0] insn_cnt_o;
    logic [TB_CNT_W-1:0] err_cnt_o;

    int                  checks = 0;
    int                  errors = 0;
    exp_t                exp_q[$];
    logic [TB_CNT_W-1:0] exp_errs = '0;

    insn_enc #(.CNT_W(TB_CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_vld_i   (req_vld_i),
        .req_rdy_o   (req_rdy_o),
        .fmt_i       (fmt_i),
        .funct3_i    (funct3_i),
        .alt_i       (alt_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .imm_i       (imm_i),
        .instr_o     (instr_o),
        .instr_vld_o (instr_vld_o),
        .instr_rdy_i (instr_rdy_i),
        .err_o       (err_o),
        .insn_cnt_o  (insn_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent model of the core's instruction-validity decode.
    function automatic logic legal(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'b0110011: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            7'b0010011: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
                return 1'b1;
            end
            7'b0000011: return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            7'b1100111: return f3 == 3'd0;
            7'b0100011: return f3 <= 3'd2;
            7'b1100011: return (f3 != 3'd2) && (f3 != 3'd3);
            7'b0110111, 7'b0010111, 7'b1101111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Consumer side: compare each word as it is handed over.
    always @(negedge clk) begin
        if (!rst_i && instr_vld_o && instr_rdy_i) begin
            exp_t e;
            chk("word_legal", {31'd0, legal(instr_o)}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", instr_o, 32'd0);
                if (instr_o == 32'd0) begin
                    errors++;
                    $error("FAIL unexpected_word: got %h expected none", instr_o);
                end
            end else begin
                e = exp_q.pop_front();
                chk("word", instr_o & e.mask, e.word & e.mask);
            end
        end
    end

    task automatic set_req(input logic [3:0] f, input logic [2:0] f3, input logic a,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        fmt_i = f; funct3_i = f3; alt_i = a; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        req_vld_i = 1'b1;
    endtask

    // Wait (bounded) for req_rdy_o, then step to the accepting edge.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_rdy_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: got req_rdy_o=0 expected 1 within 20 cycles");
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send(input logic [3:0] f, input logic [2:0] f3, input logic a,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic exp_err,
                        input logic [31:0] exp_word, input logic [31:0] mask);
        bit ok;
        set_req(f, f3, a, rd, rs1, rs2, imm);
        wait_accept(ok);
        if (ok) begin
            if (exp_err) exp_errs++;
            else exp_q.push_back('{word: exp_word, mask: mask});
        end
        #1 req_vld_i = 1'b0;
        @(negedge clk);
        chk("err_o", {31'd0, err_o}, {31'd0, exp_err});
        chk("err_cnt", {28'd0, err_cnt_o}, {28'd0, exp_errs});
    endtask

    task automatic good(input logic [3:0] f, input logic [2:0] f3, input logic a,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] w);
        send(f, f3, a, rd, rs1, rs2, imm, 1'b0, w, 32'hFFFF_FFFF);
    endtask

    task automatic bad(input logic [3:0] f, input logic [2:0] f3, input logic a,
                       input logic [31:0] imm);
        send(f, f3, a, 5'd1, 5'd1, 5'd1, imm, 1'b1, 32'd0, 32'd0);
    endtask

    initial begin
        bit ok;
        logic [31:0] r;
        logic [3:0]  f;
        logic [2:0]  f3;
        logic        a;
        logic [31:0] imm;
        logic [6:0]  opc;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_vld", {31'd0, instr_vld_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_insn_cnt", {28'd0, insn_cnt_o}, 32'd0);
        chk("rst_err_cnt", {28'd0, err_cnt_o}, 32'd0);
        chk("rst_rdy", {31'd0, req_rdy_o}, 32'd1);

        @(posedge clk);
        #1 instr_rdy_i = 1'b1;
        @(negedge clk);

        // Directed encodings and rejections
        good(FMT_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3);
        good(FMT_R, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 32'h403100B3);
        good(FMT_I_ALU, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF00293);
        bad(FMT_I_ALU, 3'b000, 1'b0, 32'h0000_0800);
        chk("err_no_word", {31'd0, instr_vld_o}, 32'd0);
        good(FMT_I_ALU, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030D093);
        bad(FMT_I_ALU, 3'b001, 1'b1, 32'd3);
        good(FMT_LUI, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 32'h123450B7);
        bad(FMT_B, 3'b000, 1'b0, 32'h0000_0005);
        good(FMT_S, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC, 32'hFE312E23);
        good(FMT_B, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463);
        good(FMT_J, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h001000EF);
        good(FMT_I_JALR, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 32'h00008067);
        good(FMT_I_LD, 3'b010, 1'b0, 5'd5, 5'd2, 5'd0, 32'd16, 32'h01012283);
        bad(FMT_I_LD, 3'b011, 1'b0, 32'd0);
        bad(FMT_AUIPC, 3'b000, 1'b0, 32'h0000_1001);
        bad(FMT_B, 3'b010, 1'b0, 32'd8);
        bad(FMT_R, 3'b001, 1'b1, 32'd0);
        bad(4'hF, 3'b000, 1'b0, 32'd0);

        // Back-to-back rejected bundles each pulse err_o
        set_req(FMT_I_JALR, 3'b001, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        wait_accept(ok);
        exp_errs++;
        #1 set_req(FMT_S, 3'b011, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
        @(negedge clk);
        chk("b2b_err_first", {31'd0, err_o}, 32'd1);
        wait_accept(ok);
        exp_errs++;
        #1 req_vld_i = 1'b0;
        @(negedge clk);
        chk("b2b_err_second", {31'd0, err_o}, 32'd1);
        @(negedge clk);
        chk("b2b_err_idle", {31'd0, err_o}, 32'd0);
        chk("b2b_err_cnt", {28'd0, err_cnt_o}, {28'd0, exp_errs});

        // Error counter wraps from all-ones to zero
        while (exp_errs != 4'hF) bad(FMT_J, 3'b000, 1'b0, 32'd1);
        chk("err_cnt_max", {28'd0, err_cnt_o}, 32'h0000_000F);
        bad(FMT_J, 3'b000, 1'b0, 32'd1);
        chk("err_cnt_wrap", {28'd0, err_cnt_o}, 32'd0);

        // Reset with two words queued discards them
        @(posedge clk);
        #1 instr_rdy_i = 1'b0;
        @(negedge clk);
        good(FMT_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3);
        good(FMT_R, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 32'h403100B3);
        chk("full_rdy", {31'd0, req_rdy_o}, 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        exp_q.delete();
        exp_errs = '0;
        @(negedge clk);
        chk("mid_rst_vld", {31'd0, instr_vld_o}, 32'd0);
        chk("mid_rst_insn_cnt", {28'd0, insn_cnt_o}, 32'd0);
        chk("mid_rst_err_cnt", {28'd0, err_cnt_o}, 32'd0);
        chk("mid_rst_rdy", {31'd0, req_rdy_o}, 32'd1);

        // Backpressure: two accepts fill the queue, third waits for space
        good(FMT_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3);
        good(FMT_LUI, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 32'h123450B7);
        set_req(FMT_R, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rdy_low", {31'd0, req_rdy_o}, 32'd0);
            chk("bp_head_hold", instr_o, 32'h003100B3);
        end
        @(posedge clk);
        #1 instr_rdy_i = 1'b1;
        wait_accept(ok);
        if (ok) exp_q.push_back('{word: 32'h403100B3, mask: 32'hFFFF_FFFF});
        #1 req_vld_i = 1'b0;
        @(negedge clk);
        chk("bp_insn_cnt", {28'd0, insn_cnt_o}, 32'd2);

        // Random legal bundles; only the opcode is predicted, validity decode checks the rest
        for (int n = 0; n < 29; n++) begin
            r   = $urandom;
            f   = 4'($urandom_range(0, 8));
            f3  = 3'($urandom_range(0, 7));
            a   = 1'($urandom_range(0, 1));
            imm = r;
            opc = 7'd0;
            case (f)
                FMT_R: begin
                    if (a) f3 = r[0] ? 3'd0 : 3'd5;
                    opc = OPC_OP;
                end
                FMT_I_ALU: begin
                    if (f3 == 3'd1 || f3 == 3'd5) imm = {27'd0, r[4:0]};
                    else imm = {{20{r[11]}}, r[11:0]};
                    if (f3 != 3'd5) a = 1'b0;
                    opc = OPC_OP_IMM;
                end
                FMT_I_LD: begin
                    if (f3 == 3'd3 || f3 >= 3'd6) f3 = 3'd2;
                    imm = {{20{r[11]}}, r[11:0]};
                    opc = OPC_LOAD;
                end
                FMT_I_JALR: begin
                    f3 = 3'd0;
                    imm = {{20{r[11]}}, r[11:0]};
                    opc = OPC_JALR;
                end
                FMT_S: begin
                    f3 = 3'(f3 % 3);
                    imm = {{20{r[11]}}, r[11:0]};
                    opc = OPC_STORE;
                end
                FMT_B: begin
                    if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd4;
                    imm = {{19{r[12]}}, r[12:1], 1'b0};
                    opc = OPC_BRANCH;
                end
                FMT_LUI: begin
                    imm = {r[31:12], 12'd0};
                    opc = OPC_LUI;
                end
                FMT_AUIPC: begin
                    imm = {r[31:12], 12'd0};
                    opc = OPC_AUIPC;
                end
                default: begin
                    imm = {{11{r[20]}}, r[20:1], 1'b0};
                    opc = OPC_JAL;
                end
            endcase
            send(f, f3, a, 5'($urandom), 5'($urandom), 5'($urandom), imm,
                 1'b0, {25'd0, opc}, 32'h0000_007F);
        end

        // Drain and check the wrapped instruction counter (3 + 29 = 32 pops)
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 32'd0);
        chk("insn_cnt_wrap", {28'd0, insn_cnt_o}, 32'd0);
        chk("final_vld", {31'd0, instr_vld_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/insn_enc.md
Name: insn_enc

Overview:
- RV32I instruction encoder: the inverse of the pipeline's instruction-validity decode.
- Accepts decoded instruction fields over a valid/ready handshake and rejects illegal field combinations.
- Assembles legal combinations into 32-bit instruction words and buffers them in a 2-entry output queue with its own valid/ready handshake.
- Used by the self-test/debug instruction injector ahead of the fetch mux; every word it emits must pass the core's validity decode.

Parameters:
- CNT_W, 16, width of the emitted-instruction and error counters (both wrap).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- req_vld_i  in  1  field bundle valid
- req_rdy_o  out  1  encoder can accept a bundle
- fmt_i  in  4  format select (insn_enc_pkg::fmt_e: R, I_ALU, I_LD, I_JALR, S, B, LUI, AUIPC, J)
- funct3_i  in  3  funct3
- alt_i  in  1  selects funct7 = 0100000 (SUB/SRA/SRAI)
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- imm_i  in  32  immediate, sign-extended byte value (U: upper 20 bits in [31:12])
- instr_o  out  32  encoded instruction at queue head
- instr_vld_o  out  1  queue non-empty
- instr_rdy_i  in  1  consumer takes head
- err_o  out  1  one-cycle pulse: last accepted bundle was rejected
- insn_cnt_o  out  CNT_W  instructions popped
- err_cnt_o  out  CNT_W  bundles rejected

Behaviour:
- Reset (rst_i high at a clock edge):
  - Queue emptied; instr_vld_o=0; instr_o=0; err_o=0; both counters=0; req_rdy_o=1 in the following cycle.
  - Reset mid-operation discards queued words with no output.
- Accept: handshake when req_vld_i && req_rdy_o. req_rdy_o = !full, registered-state only, with no combinational path from instr_rdy_i. Consequently, when full, a same-cycle pop does not enable an accept.
- Latency: bundle accepted in cycle N → word visible with instr_vld_o=1 in cycle N+1, or err_o=1 in N+1 and nothing enqueued.
- Pop: on instr_vld_o && instr_rdy_i, the head advances and insn_cnt_o increments.
- Simultaneous push and pop with 1 entry stored: count stays 1; the new word becomes head in the next cycle.
- instr_o holds its value while instr_vld_o=1 and instr_rdy_i=0.
- Encoding (opcodes as in the RV32I spec):
  - R: {alt?0100000:0000000, rs2, rs1, f3, rd, op}. Error if alt && f3∉{000,101}.
  - I_ALU, f3=001: shamt=imm[4:0]. Error if alt or imm[31:5]≠0.
  - I_ALU, f3=101: {alt?0100000:0, shamt}. Error if imm[31:5]≠0.
  - I_ALU, other f3: imm[11:0]. Error if alt.
  - I_ALU/I_LD/I_JALR/S: imm must fit 12-bit signed (imm[31:11] all equal), else error.
  - I_LD: error if f3∉{000,001,010,100,101}.
  - I_JALR: error if f3≠000.
  - S: error if f3∉{000,001,010}.
  - B: 13-bit signed, imm[0]=0. Error if f3∈{010,011}.
  - J: 21-bit signed, imm[0]=0.
  - LUI/AUIPC: error if imm[11:0]≠0.
  - Unused fields are ignored.
  - Undefined fmt_i encoding: error.
- Error path: err_o pulses for exactly one cycle per rejected bundle; err_cnt_o increments; the queue is unchanged.
- Back-to-back accepts: each error produces its own pulse.
- Counter wrap: all-ones + 1 → 0.

Decomposition:
- insn_enc_pkg holds:
  - fmt_e enum
  - 7-bit opcode constants
  - FUNCT7_BASE/FUNCT7_ALT constants
  - helper function fits_signed(value, width)
- One sub-module, insn_enc_fifo: 2-entry, 32-bit, push/pop/full/empty, synchronous active-high reset.
- The encode/check logic is combinational inside insn_enc, registered at the queue write.

Test Plan:
- R, rd=1 rs1=2 rs2=3 f3=000 alt=0 → 0x003100B3 in cycle N+1. With alt=1 → 0x403100B3.
- I_ALU, rd=5 rs1=0 imm=0xFFFFFFFF f3=000 → 0xFFF00293. Same with imm=0x00000800 → err_o pulse, err_cnt_o=1, instr_vld_o stays 0.
- I_ALU f3=101 alt=1 rd=1 rs1=1 imm=3 → 0x4030D093. f3=001 alt=1 → err_o.
- LUI rd=1 imm=0x12345000 → 0x123450B7. B with imm=0x00000005 → err_o.
- Backpressure:
  - Hold instr_rdy_i=0 and push 3 valid bundles: req_rdy_o drops after 2 accepts; instr_o stays on the first word.
  - Release instr_rdy_i: words pop in order, insn_cnt_o reaches 2, the third bundle is then accepted.
- Reset asserted with 2 words queued: next cycle instr_vld_o=0, counters=0, req_rdy_o=1. A random-legal-bundle sweep must show every emitted word passes the core validity decode.
